apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB4 requester that sits directly upstream of the APB slave memory.
- Converts a simple valid/ready request port (from a CPU/testbench/DMA front end) into compliant APB4 SETUP/ACCESS transfers.
- Waits for PREADY and returns read data plus error status on a one-cycle response strobe.
- A watchdog aborts transfers whose PREADY never arrives.

Parameters:
- ADDR_WIDTH, 32, width of req_addr/PADDR
- DATA_WIDTH, 32, width of data buses; PSTRB width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables the watchdog

Ports:
- PCLK  input  1  APB clock, all logic on rising edge
- PRESETn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request this cycle
- req_write  input  1  1=write, 0=read
- req_addr  input  ADDR_WIDTH  transfer address
- req_wdata  input  DATA_WIDTH  write data
- req_strb  input  DATA_WIDTH/8  write byte strobes
- req_prot  input  3  protection attributes
- rsp_valid  output  1  one-cycle pulse, transfer finished
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_err  output  1  PSLVERR captured, or timeout
- rsp_timeout  output  1  transfer aborted by watchdog
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  ADDR_WIDTH  APB address
- PWDATA  output  DATA_WIDTH  APB write data
- PSTRB  output  DATA_WIDTH/8  APB strobes
- PPROT  output  3  APB protection
- PRDATA  input  DATA_WIDTH  slave read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE. All outputs 0, including req_ready, PSEL, PENABLE, PADDR, PWDATA, PSTRB, PPROT, rsp_*. Watchdog counter 0.
- First edge after reset release sets req_ready=1.
- All outputs are registered. FSM states are IDLE, SETUP and ACCESS.
- IDLE: req_ready=1. When req_valid&&req_ready at an edge:
  - Latch PWRITE=req_write, PADDR=req_addr, PPROT=req_prot.
  - Latch PWDATA=req_wdata.
  - Latch PSTRB=req_strb on writes; PSTRB is forced to 0 on reads (protocol rule; the slave flags an error otherwise).
  - Set PSEL=1, PENABLE=0, req_ready=0, and go to SETUP.
- SETUP (exactly 1 cycle): next edge sets PENABLE=1 and goes to ACCESS. PSEL and all address/data/control signals stay stable.
- ACCESS: PREADY is sampled each edge.
  - PREADY=1: PSEL=0, PENABLE=0, go to IDLE, req_ready=1, rsp_valid=1 for one cycle.
  - On completion, rsp_err=PSLVERR and rsp_timeout=0.
  - On completion, rsp_rdata=PRDATA for reads, 0 for writes.
- ACCESS with PREADY=0: all APB outputs are held and the watchdog increments.
  - When TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, the transfer is aborted.
  - Abort: PSEL=0, PENABLE=0, go to IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same edge as the count reaching the limit is a normal completion; it is not a timeout.
- Watchdog clears on entry to SETUP.
- Latency: zero-wait slave gives accept edge N → SETUP N+1 → ACCESS N+2 → rsp_valid and req_ready in cycle N+3. Each PREADY-low cycle adds 1.
- Back-to-back: a new request may be accepted in the same cycle that rsp_valid is high (N+3). No IDLE-skipping; minimum 3 cycles per transfer.
- rsp_valid deasserts the cycle after its pulse. rsp_rdata, rsp_err and rsp_timeout hold until the next response.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT hold their last values after a transfer ends.
- req_* inputs are ignored outside an accept edge; changes during SETUP/ACCESS have no effect.
- PRDATA and PSLVERR are ignored except on the completing ACCESS edge.
- Reset mid-transfer: immediate return to reset values; no response is generated for the aborted transfer.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied high → PSEL high 2 cycles, PENABLE high in 2nd only, PSTRB=0xF; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read addr 0x10 with req_strb=0xF, slave returns 0xDEADBEEF → PSTRB=0 on bus; rsp_rdata=0xDEADBEEF, rsp_err=0, latency 3 cycles.
- PREADY low 3 ACCESS cycles, then high with PSLVERR=1 → APB signals stable throughout; rsp_valid at N+6, rsp_err=1, rsp_timeout=0.
- PREADY held low, TIMEOUT_CYCLES=16 → abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, PSEL=0; next request is accepted.
- req_valid held high with 4 queued writes → one accept per 3 cycles; each accept coincides with the previous rsp_valid; 4 responses in order.
- PRESETn asserted during ACCESS → PSEL, PENABLE and req_ready go 0 immediately; no rsp_valid; after release req_ready=1 and a normal transfer succeeds.

Source files
------------

// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready request into SETUP/ACCESS transfers and
// returns a one-cycle response; a watchdog aborts transfers whose PREADY never comes.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    // state  | meaning
    // IDLE   | req_ready high, waiting for a request
    // SETUP  | PSEL high, PENABLE low, exactly one cycle
    // ACCESS | PSEL and PENABLE high, waiting for PREADY or the watchdog

    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        PWRITE    <= req_write;
                        PADDR     <= req_addr;
                        PPROT     <= req_prot;
                        PWDATA    <= req_wdata;
                        // reads must present all-zero strobes on the bus
                        PSTRB     <= req_write ? req_strb : '0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b0;
                        wd_cnt    <= '0;
                        state     <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        req_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        state       <= IDLE;
                    end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        req_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a scripted slave with per-transfer wait/data/error plans,
// expected responses queued at accept time and matched by a negedge monitor.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic [2:0]    req_prot = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PSTRB(PSTRB),
        .PPROT(PPROT),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            cyc;
    } rsp_t;

    rsp_t          exp_q[$];
    rsp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            in_reset = 1'b1;
    int            acc_cnt = 0;
    int            sel_cnt = 0;

    int            plan_waits = 0;
    logic [DW-1:0] plan_rdata = '0;
    logic          plan_err = 1'b0;
    logic          cur_write = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [SW-1:0] cur_strb = '0;
    logic [2:0]    cur_prot = '0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scripted slave share one negedge process so their order is fixed.
    always @(negedge PCLK) begin
        if (!PRESETn || in_reset) begin
            sel_cnt = 0;
            acc_cnt = 0;
            PREADY  = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
                end
            end
            if (PSEL) begin
                sel_cnt++;
                chk("PENABLE_phase", 64'(PENABLE), 64'(sel_cnt > 1));
                chk("PADDR", 64'(PADDR), 64'(cur_addr));
                chk("PWRITE", 64'(PWRITE), 64'(cur_write));
                chk("PWDATA", 64'(PWDATA), 64'(cur_wdata));
                chk("PSTRB", 64'(PSTRB), 64'(cur_write ? cur_strb : '0));
                chk("PPROT", 64'(PPROT), 64'(cur_prot));
                chk("req_ready_busy", 64'(req_ready), 64'(0));
            end else begin
                sel_cnt = 0;
                chk("PENABLE_idle", 64'(PENABLE), 64'(0));
            end
            if (PSEL && PENABLE) begin
                if (acc_cnt == plan_waits) begin
                    PREADY  = 1'b1;
                    PRDATA  = plan_rdata;
                    PSLVERR = plan_err;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom);
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                PREADY  = 1'($urandom);
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                          input logic [DW-1:0] rd, input bit er, input bit hold, input bit b2b);
        int   guard;
        rsp_t e;
        guard     = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
        while (!req_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
            req_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_accept_with_rsp", 64'(rsp_valid), 64'(1));
        plan_waits = waits;
        plan_rdata = rd;
        plan_err   = er;
        cur_write  = w;
        cur_addr   = a;
        cur_wdata  = d;
        cur_strb   = s;
        cur_prot   = p;
        // Reference: a transfer times out once T ACCESS cycles pass without PREADY.
        e.tmo   = (T != 0) && (waits >= T);
        e.rdata = (e.tmo || w) ? '0 : rd;
        e.err   = e.tmo ? 1'b1 : er;
        e.cyc   = cyc + (e.tmo ? 2 + T : 3 + waits);
        exp_q.push_back(e);
        @(negedge PCLK);
        if (!hold) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_strb  = SW'($urandom);
            req_prot  = 3'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge PCLK);
    endtask

    initial begin
        bit   hold_prev;
        bit   hold_now;
        int   waits;
        PRESETn  = 1'b0;
        in_reset = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_PSEL", 64'(PSEL), 64'(0));
        chk("rst_PENABLE", 64'(PENABLE), 64'(0));
        chk("rst_PWRITE", 64'(PWRITE), 64'(0));
        chk("rst_PADDR", 64'(PADDR), 64'(0));
        chk("rst_PWDATA", 64'(PWDATA), 64'(0));
        chk("rst_PSTRB", 64'(PSTRB), 64'(0));
        chk("rst_PPROT", 64'(PPROT), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        in_reset = 1'b0;
        chk("first_edge_req_ready", 64'(req_ready), 64'(1));

        // zero-wait write, zero-wait read with strobes forced off, waited error write
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();
        do_req(1'b0, 32'h10, 32'h12345678, 4'hF, 3'd2, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        drain();
        do_req(1'b1, 32'h24, 32'hA5A5A5A5, 4'h3, 3'd5, 3, 32'h0, 1'b1, 1'b0, 1'b0);
        drain();

        // watchdog abort, then PREADY arriving on the very last allowed cycle
        do_req(1'b0, 32'h40, 32'h0, 4'hF, 3'd1, T + 4, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        drain();
        do_req(1'b0, 32'h44, 32'h0, 4'h0, 3'd1, T - 1, 32'h0BADCAFE, 1'b0, 1'b0, 1'b0);
        drain();
        do_req(1'b1, 32'h48, 32'h11111111, 4'h1, 3'd0, T, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // four queued writes with req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'h100 + 32'(i * 4), 32'hF000_0000 + 32'(i), 4'hF, 3'(i), 0,
                   32'h0, 1'b0, (i != 3), (i != 0));
        end
        drain();

        // reset during ACCESS: bus drops at once, the transfer yields no response
        do_req(1'b0, 32'h200, 32'h0, 4'h0, 3'd0, 10, 32'h77777777, 1'b0, 1'b0, 1'b0);
        @(negedge PCLK);
        #2;
        in_reset = 1'b1;
        PRESETn  = 1'b0;
        #1;
        chk("midrst_PSEL", 64'(PSEL), 64'(0));
        chk("midrst_PENABLE", 64'(PENABLE), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        in_reset = 1'b0;
        chk("postrst_req_ready", 64'(req_ready), 64'(1));
        do_req(1'b0, 32'h204, 32'h0, 4'h0, 3'd3, 1, 32'h13572468, 1'b0, 1'b0, 1'b0);
        drain();

        // randomized traffic, including back-to-back runs and timeouts
        hold_prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hold_now = (i != 59) && ($urandom_range(0, 2) == 0);
            waits = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                               : int'($urandom_range(T - 3, T + 3));
            do_req(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom), waits,
                   $urandom, 1'($urandom), hold_now, hold_prev);
            if (!hold_now && $urandom_range(0, 1) == 1) @(negedge PCLK);
            hold_prev = hold_now;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
